// File: rtl/mips_multicycle_control.sv
// rtl/mips_multicycle_control.sv - multicycle MIPS control FSM driving ALU op codes and datapath selects
module mips_multicycle_control #(
    parameter logic [2:0] ALU_OP_DEFAULT = 3'b011
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [5:0] opcode,
    input  logic [5:0] funct,
    input  logic       zero,
    output logic [2:0] alu_operation,
    output logic       alusrca,
    output logic [1:0] alusrcb,
    output logic [1:0] pcsrc,
    output logic       pc_en,
    output logic       iord,
    output logic       mem_write,
    output logic       ir_write,
    output logic       reg_dst,
    output logic       mem_to_reg,
    output logic       reg_write,
    output logic       illegal,
    output logic [3:0] state_out
);

    typedef enum logic [3:0] {
        S_FETCH   = 4'd0,
        S_DECODE  = 4'd1,
        S_MEMADR  = 4'd2,
        S_MEMRD   = 4'd3,
        S_MEMWB   = 4'd4,
        S_MEMWR   = 4'd5,
        S_EXECUTE = 4'd6,
        S_ALUWB   = 4'd7,
        S_BRANCH  = 4'd8,
        S_ADDIEX  = 4'd9,
        S_ADDIWB  = 4'd10,
        S_JUMP    = 4'd11
    } state_t;

    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_ADDI  = 6'b001000;
    localparam logic [5:0] OP_J     = 6'b000010;

    state_t     state_q;
    state_t     state_d;
    logic [2:0] funct_op;
    logic       funct_ok;

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= S_FETCH;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        funct_ok = 1'b1;
        funct_op = ALU_OP_DEFAULT;
        case (funct)
            6'b100000: funct_op = 3'b010;
            6'b100010: funct_op = 3'b110;
            6'b100100: funct_op = 3'b000;
            6'b100101: funct_op = 3'b001;
            6'b101010: funct_op = 3'b111;
            default:   funct_ok = 1'b0;
        endcase
    end

    always_comb begin
        state_d       = S_FETCH;
        alu_operation = 3'b000;
        alusrca       = 1'b0;
        alusrcb       = 2'b00;
        pcsrc         = 2'b00;
        pc_en         = 1'b0;
        iord          = 1'b0;
        mem_write     = 1'b0;
        ir_write      = 1'b0;
        reg_dst       = 1'b0;
        mem_to_reg    = 1'b0;
        reg_write     = 1'b0;
        illegal       = 1'b0;
        case (state_q)
            S_FETCH: begin
                alusrcb       = 2'b01;
                alu_operation = 3'b010;
                ir_write      = 1'b1;
                pc_en         = 1'b1;
                state_d       = S_DECODE;
            end
            S_DECODE: begin
                alusrcb       = 2'b11;
                alu_operation = 3'b010;
                case (opcode)
                    OP_LW, OP_SW: state_d = S_MEMADR;
                    OP_RTYPE:     state_d = S_EXECUTE;
                    OP_BEQ:       state_d = S_BRANCH;
                    OP_ADDI:      state_d = S_ADDIEX;
                    OP_J:         state_d = S_JUMP;
                    default:      illegal = 1'b1;
                endcase
            end
            S_MEMADR: begin
                alusrca       = 1'b1;
                alusrcb       = 2'b10;
                alu_operation = 3'b010;
                state_d       = (opcode == OP_LW) ? S_MEMRD : S_MEMWR;
            end
            S_MEMRD: begin
                iord    = 1'b1;
                state_d = S_MEMWB;
            end
            S_MEMWB: begin
                mem_to_reg = 1'b1;
                reg_write  = 1'b1;
            end
            S_MEMWR: begin
                iord      = 1'b1;
                mem_write = 1'b1;
            end
            S_EXECUTE: begin
                alusrca       = 1'b1;
                alu_operation = funct_op;
                state_d       = S_ALUWB;
            end
            S_ALUWB: begin
                reg_dst   = 1'b1;
                reg_write = funct_ok;
                illegal   = !funct_ok;
            end
            S_BRANCH: begin
                alusrca       = 1'b1;
                alu_operation = 3'b110;
                pcsrc         = 2'b01;
                pc_en         = zero;
            end
            S_ADDIEX: begin
                alusrca       = 1'b1;
                alusrcb       = 2'b10;
                alu_operation = 3'b010;
                state_d       = S_ADDIWB;
            end
            S_ADDIWB: begin
                reg_write = 1'b1;
            end
            S_JUMP: begin
                pcsrc = 2'b10;
                pc_en = 1'b1;
            end
            default: state_d = S_FETCH;
        endcase
        // Reset gates every strobe so an abandoned instruction cannot write anything.
        if (reset) begin
            alu_operation = 3'b000;
            alusrca       = 1'b0;
            alusrcb       = 2'b00;
            pcsrc         = 2'b00;
            pc_en         = 1'b0;
            iord          = 1'b0;
            mem_write     = 1'b0;
            ir_write      = 1'b0;
            reg_dst       = 1'b0;
            mem_to_reg    = 1'b0;
            reg_write     = 1'b0;
            illegal       = 1'b0;
        end
    end

    assign state_out = state_q;

endmodule
